// File: rtl/riscv_defines.sv
// Shared definitions for the instruction-port arbiter and its ID FIFO.
package riscv_defines;

  localparam int ARB_MAX_REQ   = 4;
  localparam int ARB_MAX_OUTST = 4;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int ARB_ID_W(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/riscv_arb_id_fifo.sv
// Small FIFO of requester IDs for granted transactions, in issue order.
// A push is accepted when full only if a pop happens in the same cycle.
module riscv_arb_id_fifo
  import riscv_defines::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage holds data only; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/riscv_instr_port_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port among N_REQ fetch requesters;
// responses are routed back to their issuers in issue order.
module riscv_instr_port_arbiter
  import riscv_defines::*;
#(
  parameter int N_REQ           = 2,
  parameter int RDATA_WIDTH     = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*32-1:0]    addr_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       rvalid_o,
  output logic [RDATA_WIDTH-1:0] rdata_o,
  output logic                   err_o,
  output logic                   instr_req_o,
  output logic [31:0]            instr_addr_o,
  input  logic                   instr_gnt_i,
  input  logic                   instr_rvalid_i,
  input  logic [RDATA_WIDTH-1:0] instr_rdata_i,
  input  logic                   instr_err_pmp_i,
  output logic                   busy_o,
  output logic                   proto_err_o
);

  localparam int ID_W  = ARB_ID_W(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  lock_id_q, lock_id_d;
  logic             lock_q, lock_d;
  logic             active_q;
  logic             active;
  logic [ID_W-1:0]  rr_sel, sel, head_id;
  logic             lock_hold;
  logic             can_issue, accept, resp, pop;
  logic             fifo_empty, fifo_full;
  logic [CNT_W-1:0] count;

  // Outputs stay quiet during reset and for one cycle afterwards.
  assign active = ~rst & active_q;

  always_comb begin
    int  idx;
    logic found;
    rr_sel = rr_ptr_q;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        rr_sel = ID_W'(idx);
      end
    end
  end

  // A pending unanswered request keeps the port until its owner is granted or withdraws.
  assign lock_hold = lock_q & req_i[lock_id_q];
  assign sel       = lock_hold ? lock_id_q : rr_sel;

  assign can_issue   = ~fifo_full | instr_rvalid_i;
  assign instr_req_o = active & can_issue & (|req_i);
  assign accept      = instr_req_o & instr_gnt_i;
  assign instr_addr_o = active ? addr_i[32*sel +: 32] : 32'h0;
  assign gnt_o       = accept ? (N_REQ'(1) << sel) : '0;

  assign resp        = active & instr_rvalid_i;
  assign pop         = resp & ~fifo_empty;
  assign proto_err_o = resp & fifo_empty;
  assign rvalid_o    = pop ? (N_REQ'(1) << head_id) : '0;
  assign err_o       = pop & instr_err_pmp_i;
  assign rdata_o     = instr_rdata_i;
  assign busy_o      = active & ((count != '0) | instr_req_o);

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      rr_ptr_d = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
      lock_d   = 1'b0;
    end else if (instr_req_o) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end else if (lock_q && !lock_hold) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      active_q  <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      active_q  <= 1'b1;
    end
  end

  riscv_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head_id),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (count)
  );

endmodule

// File: tb/tb_riscv_instr_port_arbiter.sv
// Directed scoreboard bench for riscv_instr_port_arbiter (N_REQ=2, MAX_OUTSTANDING=2).
module tb_riscv_instr_port_arbiter;

  localparam int N_REQ = 2;
  localparam int RDW   = 32;
  localparam int MAXO  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] req_i;
  logic [N_REQ*32-1:0] addr_i;
  logic [N_REQ-1:0] gnt_o, rvalid_o;
  logic [RDW-1:0]   rdata_o, instr_rdata_i;
  logic             err_o, instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_pmp_i;
  logic [31:0]      instr_addr_o;
  logic             busy_o, proto_err_o;

  int vectors = 0;
  int fails   = 0;

  logic [N_REQ+31:0]  exp_gnt_q [$];
  logic [N_REQ+32:0]  exp_rsp_q [$];

  always #5 clk = ~clk;

  riscv_instr_port_arbiter #(
    .N_REQ(N_REQ), .RDATA_WIDTH(RDW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_err_pmp_i(instr_err_pmp_i), .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N_REQ-1:0] rq, input logic g, input logic rv,
                       input logic [31:0] rd, input logic e);
    req_i = rq; instr_gnt_i = g; instr_rvalid_i = rv; instr_rdata_i = rd; instr_err_pmp_i = e;
  endtask

  task automatic exp_gnt(input logic [N_REQ-1:0] g, input logic [31:0] a);
    exp_gnt_q.push_back({g, a});
  endtask

  task automatic exp_rsp(input logic [N_REQ-1:0] v, input logic [31:0] d, input logic e);
    exp_rsp_q.push_back({v, d, e});
  endtask

  task automatic reset_dut();
    drive('0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Monitor: every grant and every response is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (gnt_o !== '0) begin
        if (exp_gnt_q.size() == 0) check("unexpected_gnt", 64'(gnt_o), 64'h0);
        else check("gnt_addr", 64'({gnt_o, instr_addr_o}), 64'(exp_gnt_q.pop_front()));
      end
      if (rvalid_o !== '0) begin
        if (exp_rsp_q.size() == 0) check("unexpected_rvalid", 64'(rvalid_o), 64'h0);
        else check("rsp", 64'({rvalid_o, rdata_o, err_o}), 64'(exp_rsp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    addr_i = '0;
    rst = 1'b1;
    drive(2'b11, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    check("rst_req", 64'(instr_req_o), 64'h0);
    check("rst_gnt", 64'(gnt_o), 64'h0);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_proto", 64'(proto_err_o), 64'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req", 64'(instr_req_o), 64'h0);
    check("post_rst_rvalid", 64'(rvalid_o), 64'h0);
    tick();

    // Single requester, response two cycles after grant.
    addr_i[31:0] = 32'h1C00_0080;
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    exp_gnt(2'b01, 32'h1C00_0080);
    @(negedge clk);
    check("t1_req", 64'(instr_req_o), 64'h1);
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'h0000_0013, 1'b0);
    exp_rsp(2'b01, 32'h0000_0013, 1'b0);
    @(negedge clk);
    check("t1_busy", 64'(busy_o), 64'h1);
    tick();
    // Response with nothing outstanding.
    drive(2'b00, 1'b0, 1'b1, 32'h5555_5555, 1'b0);
    @(negedge clk);
    check("stray_proto", 64'(proto_err_o), 64'h1);
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("stray_proto_clr", 64'(proto_err_o), 64'h0);
    tick();

    // Both requesting continuously: grants alternate from requester 0.
    reset_dut();
    addr_i = {32'hB000_0004, 32'hA000_0000};
    drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
    exp_gnt(2'b01, 32'hA000_0000); tick();
    exp_gnt(2'b10, 32'hB000_0004); tick();
    drive(2'b11, 1'b1, 1'b1, 32'hD000_0001, 1'b0);
    exp_rsp(2'b01, 32'hD000_0001, 1'b0); exp_gnt(2'b01, 32'hA000_0000); tick();
    drive(2'b11, 1'b1, 1'b1, 32'hD000_0002, 1'b0);
    exp_rsp(2'b10, 32'hD000_0002, 1'b0); exp_gnt(2'b10, 32'hB000_0004); tick();
    drive(2'b00, 1'b0, 1'b1, 32'hD000_0003, 1'b0);
    exp_rsp(2'b01, 32'hD000_0003, 1'b0); tick();
    drive(2'b00, 1'b0, 1'b1, 32'hD000_0004, 1'b0);
    exp_rsp(2'b10, 32'hD000_0004, 1'b0); tick();

    // Requester 1 stalled without grant keeps the port while requester 0 rises.
    reset_dut();
    addr_i = {32'h0000_0200, 32'h0000_0100};
    drive(2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t3_addr_c1", 64'(instr_addr_o), 64'h200);
    check("t3_req_c1", 64'(instr_req_o), 64'h1);
    tick();
    drive(2'b11, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t3_addr_c2", 64'(instr_addr_o), 64'h200);
    tick();
    @(negedge clk);
    check("t3_addr_c3", 64'(instr_addr_o), 64'h200);
    tick();
    drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
    exp_gnt(2'b10, 32'h0000_0200); tick();
    exp_gnt(2'b01, 32'h0000_0100); tick();
    drive(2'b00, 1'b0, 1'b1, 32'h0000_0A01, 1'b0);
    exp_rsp(2'b10, 32'h0000_0A01, 1'b0); tick();
    drive(2'b00, 1'b0, 1'b1, 32'h0000_0A00, 1'b0);
    exp_rsp(2'b01, 32'h0000_0A00, 1'b0); tick();

    // Outstanding limit and same-cycle slot release.
    reset_dut();
    addr_i = {32'h0, 32'h0000_0040};
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    exp_gnt(2'b01, 32'h40); tick();
    exp_gnt(2'b01, 32'h40); tick();
    @(negedge clk);
    check("t4_full_req", 64'(instr_req_o), 64'h0);
    check("t4_full_busy", 64'(busy_o), 64'h1);
    tick();
    drive(2'b01, 1'b1, 1'b1, 32'hE000_0001, 1'b0);
    exp_rsp(2'b01, 32'hE000_0001, 1'b0); exp_gnt(2'b01, 32'h40);
    @(negedge clk);
    check("t4_release_req", 64'(instr_req_o), 64'h1);
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'hE000_0002, 1'b0);
    exp_rsp(2'b01, 32'hE000_0002, 1'b0); tick();
    drive(2'b00, 1'b0, 1'b1, 32'hE000_0003, 1'b0);
    exp_rsp(2'b01, 32'hE000_0003, 1'b0); tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t4_idle_busy", 64'(busy_o), 64'h0);
    tick();

    // Interleaved issue r0,r1,r0 with an error on the second response.
    addr_i = {32'h0000_2000, 32'h0000_1000};
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    exp_gnt(2'b01, 32'h1000); tick();
    drive(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
    exp_gnt(2'b10, 32'h2000); tick();
    drive(2'b01, 1'b1, 1'b1, 32'hD0D0_0000, 1'b0);
    exp_rsp(2'b01, 32'hD0D0_0000, 1'b0); exp_gnt(2'b01, 32'h1000); tick();
    drive(2'b00, 1'b0, 1'b1, 32'hD1D1_0001, 1'b1);
    exp_rsp(2'b10, 32'hD1D1_0001, 1'b1); tick();
    drive(2'b00, 1'b0, 1'b1, 32'hD2D2_0002, 1'b0);
    exp_rsp(2'b01, 32'hD2D2_0002, 1'b0); tick();

    // Reset with two outstanding; the late response is dropped.
    addr_i = {32'h0, 32'h0000_3000};
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    exp_gnt(2'b01, 32'h3000); tick();
    exp_gnt(2'b01, 32'h3000); tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_busy", 64'(busy_o), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    drive(2'b00, 1'b0, 1'b1, 32'hBAD0_0000, 1'b0);
    @(negedge clk);
    check("t6_proto", 64'(proto_err_o), 64'h1);
    check("t6_rvalid", 64'(rvalid_o), 64'h0);
    check("t6_busy", 64'(busy_o), 64'h0);
    tick();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("t6_proto_pulse", 64'(proto_err_o), 64'h0);
    tick();

    check("gnt_queue_drained", 64'(exp_gnt_q.size()), 64'h0);
    check("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
